fetch_sequencer: RTL and testbench

Parametrised instruction-fetch sequencer for the multicycle generation of the MIPS core. It replaces the free-running PC register and the adder/mux next-PC path of the single-cycle CPU. It owns the program counter and fetches over a ready/valid instruction-memory handshake. It resolves branch, jump and jump-register redirects and holds each instruction stable for decode/execute until the core releases it.

---
 rtl/fetch_sequencer.sv | 133 +++++++++++++
 tb/tb_fetch_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, fetches over a ready/valid imem handshake,
// holds each instruction until the core releases it, and resolves
// branch / jump / jump-register redirects.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (trap to HALT on a
// misaligned next PC instead of silently clearing bits [1:0]).
module fetch_sequencer #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_valid,
  input  logic [31:0]      imem_data,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] link_addr,
  input  logic             branch,
  input  logic             branch_ne,
  input  logic             zero,
  input  logic [WIDTH-1:0] imm_ex,
  input  logic             jump,
  input  logic [25:0]      jump_addr,
  input  logic             jump_reg,
  input  logic [WIDTH-1:0] reg_target,
  output logic             misalign
);

  localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, HALT} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  pc_q, pc_d;
  logic [WIDTH-1:0]  pc_out_q, pc_out_d;
  logic [31:0]       instr_q, instr_d;
  logic [WIDTH-1:0]  link;
  logic [31:0]       jump_tgt32;
  logic              taken;
  logic [WIDTH-1:0]  target;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic              misalign_q, misalign_d;
`endif

  assign link       = pc_out_q + FOUR;
  assign jump_tgt32 = (32'(link) & 32'hF000_0000) | {4'b0000, jump_addr, 2'b00};
  assign taken      = branch & (zero ^ branch_ne);

  // Next-PC selection, highest priority first.
  always_comb begin
    target = link;
    if (jump_reg)   target = reg_target;
    else if (jump)  target = WIDTH'(jump_tgt32);
    else if (taken) target = link + (imm_ex << 2);
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_d = misalign_q;
`endif
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_valid) begin
          instr_d  = imem_data;
          pc_out_d = pc_q;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (!stall) begin
`ifdef FETCH_MISALIGN_TRAP_EN
          if (target[1:0] != 2'b00) begin
            misalign_d = 1'b1;
            state_d    = HALT;
          end else begin
            pc_d    = target;
            state_d = REQ;
          end
`else
          pc_d    = target & ALIGN_MASK;
          state_d = REQ;
`endif
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_VECTOR;
      pc_out_q <= RESET_VECTOR;
      instr_q  <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign imem_req    = (state_q == REQ);
  assign instr_valid = (state_q == HOLD);
  assign imem_addr   = pc_q;
  assign pc_out      = pc_out_q;
  assign instr       = instr_q;
  assign link_addr   = link;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign    = misalign_q;
`else
  assign misalign    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: table of redirect vectors plus hand sequences
// for stall, misaligned jump-register and reset mid-fetch.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, imem_valid;
  logic [31:0] imem_data;
  logic        imem_req, instr_valid, misalign;
  logic [31:0] imem_addr, instr, pc_out, link_addr;
  logic        branch, branch_ne, zero, jump, jump_reg;
  logic [31:0] imm_ex, reg_target;
  logic [25:0] jump_addr;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_data = 32'h0;

  typedef struct {
    logic        br, bne, z, j, jr;
    logic [31:0] imm;
    logic [25:0] ja;
    logic [31:0] rt;
    logic [31:0] exp;
    int          waits;
  } vec_t;

  vec_t vecs[16];

  fetch_sequencer #(.WIDTH(32), .RESET_VECTOR(32'h40)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data),
    .instr(instr), .instr_valid(instr_valid),
    .pc_out(pc_out), .link_addr(link_addr),
    .branch(branch), .branch_ne(branch_ne), .zero(zero), .imm_ex(imm_ex),
    .jump(jump), .jump_addr(jump_addr),
    .jump_reg(jump_reg), .reg_target(reg_target),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic clear_redirect();
    branch = 0; branch_ne = 0; zero = 0; jump = 0; jump_reg = 0;
    imm_ex = 0; jump_addr = 0; reg_target = 0;
  endtask

  // Release HOLD for one cycle with the given redirect inputs.
  task automatic release_hold(input vec_t v, input bit push);
    branch = v.br; branch_ne = v.bne; zero = v.z; jump = v.j; jump_reg = v.jr;
    imm_ex = v.imm; jump_addr = v.ja; reg_target = v.rt;
    stall = 1'b0;
    if (push) exp_q.push_back(v.exp);
    @(negedge clk);
    stall = 1'b1;
    clear_redirect();
    chk("iv_drop", 32'(instr_valid), 32'd0);
  endtask

  // Wait (bounded) for a request; returns 1 if one was seen.
  task automatic wait_req(output bit ok);
    int n = 0;
    while (!imem_req && n < 50) begin @(negedge clk); n++; end
    ok = imem_req;
    if (!ok) chk("req_timeout", 32'd0, 32'd1);
  endtask

  // Serve one fetch with the given number of wait cycles; scoreboard checks address.
  task automatic do_fetch(input int waits, input logic [31:0] data);
    bit ok;
    logic [31:0] ea, prev;
    wait_req(ok);
    if (!ok) return;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    ea   = exp_q.pop_front();
    prev = instr;
    chk("fetch_addr", imem_addr, ea);
    for (int i = 0; i < waits; i++) begin
      imem_valid = 1'b0;
      imem_data  = ~data;
      @(negedge clk);
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", imem_addr, ea);
      chk("wait_instr", instr, prev);
    end
    imem_valid = 1'b1;
    imem_data  = data;
    @(negedge clk);
    imem_valid = 1'b0;
    last_data  = data;
    chk("iv_high", 32'(instr_valid), 32'd1);
    chk("hold_req", 32'(imem_req), 32'd0);
    chk("instr", instr, data);
    chk("pc_out", pc_out, ea);
    chk("link", link_addr, ea + 32'd4);
  endtask

  initial begin
    vec_t v;
    bit   ok;
    // br bne z j jr imm ja rt exp waits
    vecs[0]  = '{0,0,0,0,0, 32'h0,        26'h0,       32'h0,        32'h44,       3};
    vecs[1]  = '{0,0,0,0,1, 32'h0,        26'h0,       32'h100,      32'h100,      0};
    vecs[2]  = '{1,0,1,0,0, 32'hFFFFFFFE, 26'h0,       32'h0,        32'hFC,       1};
    vecs[3]  = '{0,0,0,0,1, 32'h0,        26'h0,       32'h100,      32'h100,      0};
    vecs[4]  = '{1,1,1,0,0, 32'hFFFFFFFE, 26'h0,       32'h0,        32'h104,      2};
    vecs[5]  = '{0,0,0,1,1, 32'h0,        26'h10,      32'h2000,     32'h2000,     0};
    vecs[6]  = '{0,0,0,0,1, 32'h0,        26'h0,       32'h100,      32'h100,      1};
    vecs[7]  = '{0,0,0,1,0, 32'h0,        26'h10,      32'h0,        32'h40,       0};
    vecs[8]  = '{1,1,0,0,0, 32'h10,       26'h0,       32'h0,        32'h84,       2};
    vecs[9]  = '{1,0,0,0,0, 32'h10,       26'h0,       32'h0,        32'h88,       0};
    vecs[10] = '{0,0,0,1,0, 32'h0,        26'h3FFFFFF, 32'h0,        32'h0FFFFFFC, 1};
    vecs[11] = '{0,0,0,0,0, 32'h0,        26'h0,       32'h0,        32'h10000000, 0};
    vecs[12] = '{1,0,1,1,0, 32'h40,       26'h1,       32'h0,        32'h10000004, 0};
    vecs[13] = '{0,0,0,0,1, 32'h0,        26'h0,       32'hFFFFFFFC, 32'hFFFFFFFC, 1};
    vecs[14] = '{0,0,0,0,0, 32'h0,        26'h0,       32'h0,        32'h0,        0};
    vecs[15] = '{0,0,0,0,1, 32'h0,        26'h0,       32'h100,      32'h100,      0};

    reset = 1'b1; stall = 1'b1; imem_valid = 1'b0; imem_data = 32'h0;
    clear_redirect();
    @(negedge clk); @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h40);
    chk("rst_pc_out", pc_out, 32'h40);
    chk("rst_instr", instr, 32'h0);
    chk("rst_iv", 32'(instr_valid), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    reset = 1'b0;
    chk("idle_req", 32'(imem_req), 32'd0);
    exp_q.push_back(32'h40);
    do_fetch(0, 32'hC0DE_0040);

    for (int i = 0; i < 16; i++) begin
      release_hold(vecs[i], 1'b1);
      do_fetch(vecs[i].waits, 32'hA5A5_0000 + 32'(i));
    end

    // Stall at 0x100 while redirect inputs toggle; only release-cycle inputs matter.
    for (int k = 0; k < 5; k++) begin
      branch = k[0]; zero = 1'b1; imm_ex = 32'h100; jump = ~k[0]; jump_addr = 26'h55;
      jump_reg = k[1]; reg_target = 32'h3000;
      @(negedge clk);
      chk("stall_instr", instr, last_data);
      chk("stall_pc", pc_out, 32'h100);
      chk("stall_req", 32'(imem_req), 32'd0);
      chk("stall_iv", 32'(instr_valid), 32'd1);
    end
    v = '{0,0,0,0,0, 32'h0, 26'h0, 32'h0, 32'h104, 0};
    release_hold(v, 1'b1);
    do_fetch(0, 32'h1234_5678);

    // Misaligned jump-register target from 0x104.
    v = '{0,0,0,0,1, 32'h0, 26'h0, 32'h2002, 32'h2000, 0};
`ifdef FETCH_MISALIGN_TRAP_EN
    release_hold(v, 1'b0);
    chk("trap_misalign", 32'(misalign), 32'd1);
    chk("trap_pc_out", pc_out, 32'h104);
    for (int k = 0; k < 4; k++) begin
      imem_valid = 1'b1;
      @(negedge clk);
      chk("halt_req", 32'(imem_req), 32'd0);
      chk("halt_iv", 32'(instr_valid), 32'd0);
    end
    imem_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("halt_rst_misalign", 32'(misalign), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(32'h40);
    do_fetch(0, 32'h0BAD_0040);
    v = '{0,0,0,0,0, 32'h0, 26'h0, 32'h0, 32'h44, 0};
    release_hold(v, 1'b1);
`else
    release_hold(v, 1'b1);
    do_fetch(1, 32'h2000_0000);
    chk("no_misalign", 32'(misalign), 32'd0);
    v = '{0,0,0,0,0, 32'h0, 26'h0, 32'h0, 32'h2004, 0};
    release_hold(v, 1'b1);
`endif

    // Reset asserted mid-REQ with a response arriving alongside it.
    wait_req(ok);
    if (ok && exp_q.size() > 0) chk("midreq_addr", imem_addr, exp_q.pop_front());
    @(negedge clk);
    imem_valid = 1'b1;
    imem_data  = 32'hDEAD_BEEF;
    reset      = 1'b1;
    #1;
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    chk("mid_rst_addr", imem_addr, 32'h40);
    chk("mid_rst_pc", pc_out, 32'h40);
    chk("mid_rst_instr", instr, 32'h0);
    chk("mid_rst_iv", 32'(instr_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("post_rst_iv", 32'(instr_valid), 32'd0);
    chk("post_rst_instr", instr, 32'h0);
    imem_valid = 1'b0;
    exp_q.push_back(32'h40);
    do_fetch(1, 32'h0000_0040);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
